// File: rtl/chk4_symbol_tx.sv
// Transmit side of the 4-bit check-symbol link: buffers 3-bit payloads, prepends the check bit
// and serialises each symbol MSB-first on a valid/ready bit stream with an idle gap.
module chk4_symbol_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          tx_bit,
  output logic                          tx_sof,
  output logic                          tx_eof,
  output logic [CNT_W-1:0]              sym_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GW-1:0] GapLast = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e          state_q, state_d;
  logic [2:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [3:0]      sh_q, sh_d;
  logic [1:0]      idx_q, idx_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            push, pop, empty, full, try_load;
  logic [2:0]      head;
  logic            head_chk;

  assign full       = (level_q == LW'(FIFO_DEPTH));
  assign empty      = (level_q == '0);
  assign in_ready   = ~rst & ~full;
  assign push       = in_valid & in_ready;
  assign head       = mem_q[rd_ptr_q];
  // Check bit is set when at most one payload bit is high
  assign head_chk   = ~((head[2] & head[1]) | (head[2] & head[0]) | (head[1] & head[0]));
  assign sym_count  = cnt_q;
  assign fifo_level = level_q;

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    try_load = 1'b0;
    tx_valid = 1'b0;
    tx_bit   = 1'b0;
    tx_sof   = 1'b0;
    tx_eof   = 1'b0;
    unique case (state_q)
      StIdle: try_load = 1'b1;
      StShift: begin
        tx_valid = 1'b1;
        tx_bit   = sh_q[3];
        tx_sof   = (idx_q == 2'd0);
        tx_eof   = (idx_q == 2'd3);
        if (tx_ready) begin
          sh_d  = {sh_q[2:0], 1'b0};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (GAP_CYCLES > 0) begin
              state_d = StGap;
              gap_d   = '0;
            end else begin
              try_load = 1'b1;
            end
          end
        end
      end
      StGap: begin
        // The last gap cycle already pops, so the next sof follows exactly GAP_CYCLES idles
        if (gap_q == GapLast) try_load = 1'b1;
        else gap_d = gap_q + GW'(1);
      end
      default: state_d = StIdle;
    endcase
    if (try_load) begin
      if (!empty) begin
        pop     = 1'b1;
        sh_d    = {head_chk, head};
        idx_d   = 2'd0;
        state_d = StShift;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sh_q     <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_chk4_symbol_tx.sv
// Scoreboard bench for chk4_symbol_tx: instance a (gap 1, 4-bit counter), instance b (gap 0).
module tb_chk4_symbol_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, in_valid_a, in_ready_a, tx_valid_a, tx_ready_a, tx_bit_a, tx_sof_a, tx_eof_a;
  logic [2:0] in_data_a, fifo_level_a;
  logic [3:0] sym_count_a;
  logic       rst_b, in_valid_b, in_ready_b, tx_valid_b, tx_ready_b, tx_bit_b, tx_sof_b, tx_eof_b;
  logic [2:0] in_data_b, fifo_level_b;
  logic [15:0] sym_count_b;

  chk4_symbol_tx #(.FIFO_DEPTH(4), .GAP_CYCLES(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_bit(tx_bit_a), .tx_sof(tx_sof_a),
    .tx_eof(tx_eof_a), .sym_count(sym_count_a), .fifo_level(fifo_level_a)
  );

  chk4_symbol_tx #(.FIFO_DEPTH(4), .GAP_CYCLES(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_bit(tx_bit_b), .tx_sof(tx_sof_b),
    .tx_eof(tx_eof_b), .sym_count(sym_count_b), .fifo_level(fifo_level_b)
  );

  // Hand-computed symbols {chk, d2, d1, d0} for payloads 0..7
  logic [3:0] sym_tbl [8] = '{4'b1000, 4'b1001, 4'b1010, 4'b0011,
                              4'b1100, 4'b0101, 4'b0110, 4'b0111};

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit rec_sof = 0;
  logic [3:0] exp_q_a [$];
  logic [3:0] exp_q_b [$];
  int sofs_a [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Monitor a: assemble symbols, check framing and counter at each eof
  initial begin
    logic [3:0] asm_a;
    int nb_a, cnt_a;
    asm_a = '0; nb_a = 0; cnt_a = 0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        asm_a = '0; nb_a = 0; cnt_a = 0;
        exp_q_a.delete();
      end else if (tx_valid_a && tx_ready_a) begin
        check("a_sof", int'(tx_sof_a), int'(nb_a == 0));
        check("a_eof", int'(tx_eof_a), int'(nb_a == 3));
        if (tx_sof_a && rec_sof) sofs_a.push_back(cyc);
        asm_a = {asm_a[2:0], tx_bit_a};
        nb_a++;
        if (nb_a == 4) begin
          nb_a = 0;
          if (exp_q_a.size() == 0) fail_now("a_sym unexpected symbol");
          else check("a_sym", int'(asm_a), int'(exp_q_a.pop_front()));
          check("a_cnt", int'(sym_count_a), cnt_a % 16);
          cnt_a++;
        end
      end
    end
  end

  // Monitor b: same, plus eof must be followed directly by sof while symbols are pending
  initial begin
    logic [3:0] asm_b;
    int nb_b, cnt_b;
    bit b2b;
    asm_b = '0; nb_b = 0; cnt_b = 0; b2b = 0;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        asm_b = '0; nb_b = 0; cnt_b = 0; b2b = 0;
        exp_q_b.delete();
      end else begin
        if (b2b) begin
          check("b_back_to_back", int'(tx_valid_b && tx_sof_b), 1);
          b2b = 0;
        end
        if (tx_valid_b && tx_ready_b) begin
          check("b_sof", int'(tx_sof_b), int'(nb_b == 0));
          check("b_eof", int'(tx_eof_b), int'(nb_b == 3));
          asm_b = {asm_b[2:0], tx_bit_b};
          nb_b++;
          if (nb_b == 4) begin
            nb_b = 0;
            if (exp_q_b.size() == 0) fail_now("b_sym unexpected symbol");
            else check("b_sym", int'(asm_b), int'(exp_q_b.pop_front()));
            check("b_cnt", int'(sym_count_b), cnt_b % 65536);
            cnt_b++;
            b2b = (exp_q_b.size() != 0);
          end
        end
      end
    end
  end

  // Entered and left at posedge+1
  task automatic push(input bit b, input logic [2:0] d);
    int n;
    bit ok;
    n = 0; ok = 1;
    if (b) begin in_valid_b = 1'b1; in_data_b = d; end
    else   begin in_valid_a = 1'b1; in_data_a = d; end
    forever begin
      @(negedge clk);
      if (b ? in_ready_b : in_ready_a) break;
      n++;
      if (n > 200) begin fail_now("push timeout"); ok = 0; break; end
    end
    if (ok) begin
      if (b) exp_q_b.push_back(sym_tbl[d]);
      else   exp_q_a.push_back(sym_tbl[d]);
    end
    @(posedge clk);
    #1;
    if (b) in_valid_b = 1'b0;
    else   in_valid_a = 1'b0;
  endtask

  task automatic wait_drain(input bit b);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (b ? (exp_q_b.size() == 0 && !tx_valid_b) : (exp_q_a.size() == 0 && !tx_valid_a)) break;
      n++;
      if (n > 1000) begin fail_now("drain timeout"); break; end
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int exp_v [6] = '{0, 1, 1, 1, 1, 0};
    int exp_s [6] = '{0, 1, 0, 0, 0, 0};
    int exp_e [6] = '{0, 0, 0, 0, 1, 0};
    int exp_d [6] = '{0, 1, 1, 0, 0, 0};
    int lv_b [5]  = '{1, 1, 2, 3, 4};
    logic [2:0] pay_b [5] = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd3};
    int n, cnt_before;

    rst_a = 1; rst_b = 1;
    in_valid_a = 0; in_valid_b = 0; in_data_a = '0; in_data_b = '0;
    tx_ready_a = 1; tx_ready_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("a_in_ready_in_reset", int'(in_ready_a), 0);
    check("b_in_ready_in_reset", int'(in_ready_b), 0);
    @(posedge clk); #1;
    rst_a = 0; rst_b = 0;
    @(negedge clk);
    check("a_rst_in_ready", int'(in_ready_a), 1);
    check("a_rst_tx_valid", int'(tx_valid_a), 0);
    check("a_rst_tx_bit", int'(tx_bit_a), 0);
    check("a_rst_sof_eof", int'({tx_sof_a, tx_eof_a}), 0);
    check("a_rst_sym_count", int'(sym_count_a), 0);
    check("a_rst_fifo_level", int'(fifo_level_a), 0);
    check("b_rst_fifo_level", int'(fifo_level_b), 0);
    @(posedge clk); #1;

    // Check table: payloads 0..7, sof every 5 cycles
    rec_sof = 1;
    for (int i = 0; i < 8; i++) push(0, 3'(i));
    wait_drain(0);
    rec_sof = 0;
    check("a_sof_count", sofs_a.size(), 8);
    for (int i = 1; i < sofs_a.size(); i++) check("a_sof_spacing", sofs_a[i] - sofs_a[i-1], 5);
    check("a_sym_count_8", int'(sym_count_a), 8);

    // Latency and framing of a single payload 3'b100
    in_valid_a = 1; in_data_a = 3'b100;
    exp_q_a.push_back(sym_tbl[4]);
    @(negedge clk);
    check("lat_in_ready", int'(in_ready_a), 1);
    @(posedge clk); #1;
    in_valid_a = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("lat_tx_valid", int'(tx_valid_a), exp_v[k]);
      check("lat_tx_sof", int'(tx_sof_a), exp_s[k]);
      check("lat_tx_eof", int'(tx_eof_a), exp_e[k]);
      check("lat_tx_bit", int'(tx_bit_a), exp_d[k]);
    end
    wait_drain(0);

    // Backpressure on bit index 1 of payload 3'b011
    cnt_before = int'(sym_count_a);
    push(0, 3'b011);
    n = 0;
    forever begin
      @(negedge clk);
      if (tx_valid_a && tx_sof_a) break;
      n++;
      if (n > 20) begin fail_now("bp sof timeout"); break; end
    end
    @(posedge clk); #1;
    tx_ready_a = 0;
    repeat (3) begin
      @(negedge clk);
      check("bp_tx_valid", int'(tx_valid_a), 1);
      check("bp_tx_bit", int'(tx_bit_a), 0);
      check("bp_sof_eof", int'({tx_sof_a, tx_eof_a}), 0);
    end
    @(posedge clk); #1;
    tx_ready_a = 1;
    wait_drain(0);
    check("bp_sym_count", int'(sym_count_a), (cnt_before + 1) % 16);

    // Reset at bit index 2 of payload 3'b010 with two entries queued
    push(0, 3'b010);
    push(0, 3'b001);
    push(0, 3'b100);
    @(posedge clk); #1;
    rst_a = 1;
    @(negedge clk);
    check("rst_mid_bit_idx2", int'(tx_bit_a), 1);
    check("rst_mid_valid", int'(tx_valid_a), 1);
    check("rst_mid_level", int'(fifo_level_a), 2);
    check("rst_mid_in_ready", int'(in_ready_a), 0);
    @(posedge clk); #1;
    rst_a = 0;
    @(negedge clk);
    check("rst_after_valid", int'(tx_valid_a), 0);
    check("rst_after_level", int'(fifo_level_a), 0);
    check("rst_after_count", int'(sym_count_a), 0);
    repeat (8) begin
      @(negedge clk);
      check("rst_quiet_valid", int'(tx_valid_a), 0);
    end
    @(posedge clk); #1;

    // Counter wrap with a 4-bit counter: 17 symbols
    for (int i = 0; i < 17; i++) push(0, 3'(i % 8));
    wait_drain(0);
    check("wrap_sym_count", int'(sym_count_a), 1);

    // FIFO full on instance b (no gap), tx stalled
    for (int i = 0; i < 5; i++) begin
      push(1, pay_b[i]);
      @(negedge clk);
      check("full_level", int'(fifo_level_b), lv_b[i]);
      if (i == 3) check("full_valid_held", int'(tx_valid_b), 1);
      @(posedge clk); #1;
    end
    check("full_in_ready", int'(in_ready_b), 0);
    in_valid_b = 1; in_data_b = 3'b111;
    repeat (3) begin
      @(negedge clk);
      check("full_ignore_level", int'(fifo_level_b), 4);
      check("full_ignore_ready", int'(in_ready_b), 0);
    end
    @(posedge clk); #1;
    in_valid_b = 0;
    tx_ready_b = 1;
    wait_drain(1);
    check("full_sym_count", int'(sym_count_b), 5);
    repeat (4) begin
      @(negedge clk);
      check("full_no_extra", int'(tx_valid_b), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
